// File: rtl/memory_tester.sv
// Four-phase dual-port RAM self-test: W1 (port 1 writes A), R2 (port 2 verifies), W2 (port 2 writes ~A), R1 (port 1 verifies).
// Optional MEMORY_TESTER_STOP_ON_ERROR_EN ends the run at the first mismatch.
module memory_tester #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned SEED         = 'hA5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           error_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic                  enable1,
  output logic                  write1,
  output logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] idata1,
  input  logic [DATA_WIDTH-1:0] odata1,
  output logic                  enable2,
  output logic                  write2,
  output logic [ADDR_WIDTH-1:0] addr2,
  output logic [DATA_WIDTH-1:0] idata2,
  input  logic [DATA_WIDTH-1:0] odata2
);

  typedef enum logic [2:0] {IDLE, W1, R2, D2, W2, R1, D1, DONE} state_t;

  localparam logic [1:0] DRAIN_LAST = 2'(READ_LATENCY - 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic [1:0]            dcnt, dcnt_nxt;
  logic                  rd_issue, rd_sel, start_run, mismatch, stop;

  // Per-read pipeline: valid, address and which port (1 = port 1, expects ~A)
  logic [READ_LATENCY-1:0] vld_sr, sel_sr;
  logic [ADDR_WIDTH-1:0]   addr_sr [READ_LATENCY];

  logic [ADDR_WIDTH-1:0] cmp_addr;
  logic [DATA_WIDTH-1:0] exp_word, rdata;

  function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a);
    return DATA_WIDTH'(a) ^ DATA_WIDTH'(SEED);
  endfunction

  assign busy      = (state != IDLE) && (state != DONE);
  assign start_run = ((state == IDLE) || (state == DONE)) && start;
  assign cmp_addr  = addr_sr[READ_LATENCY-1];
  assign exp_word  = sel_sr[READ_LATENCY-1] ? ~pat(cmp_addr) : pat(cmp_addr);
  assign rdata     = sel_sr[READ_LATENCY-1] ? odata1 : odata2;
  assign mismatch  = vld_sr[READ_LATENCY-1] && (rdata != exp_word);

`ifdef MEMORY_TESTER_STOP_ON_ERROR_EN
  assign stop = mismatch;
`else
  assign stop = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dcnt_nxt  = dcnt;
    rd_issue  = 1'b0;
    rd_sel    = 1'b0;
    enable1   = 1'b0;
    write1    = 1'b0;
    addr1     = '0;
    idata1    = '0;
    enable2   = 1'b0;
    write2    = 1'b0;
    addr2     = '0;
    idata2    = '0;
    case (state)
      IDLE, DONE: if (start) begin
        state_nxt = W1;
        cnt_nxt   = '0;
      end
      W1: begin
        enable1 = 1'b1;
        write1  = 1'b1;
        addr1   = cnt;
        idata1  = pat(cnt);
        cnt_nxt = cnt + 1'b1;
        if (cnt == '1) state_nxt = R2;
      end
      R2: begin
        enable2  = 1'b1;
        addr2    = cnt;
        rd_issue = 1'b1;
        cnt_nxt  = cnt + 1'b1;
        if (cnt == '1) begin
          state_nxt = D2;
          dcnt_nxt  = '0;
        end
      end
      D2: begin
        dcnt_nxt = dcnt + 2'd1;
        if (dcnt == DRAIN_LAST) begin
          state_nxt = W2;
          cnt_nxt   = '1;
        end
      end
      W2: begin
        enable2 = 1'b1;
        write2  = 1'b1;
        addr2   = cnt;
        idata2  = ~pat(cnt);
        // Descending phase: hold at 0 on exit so R1 starts at address 0
        if (cnt == '0) state_nxt = R1;
        else           cnt_nxt   = cnt - 1'b1;
      end
      R1: begin
        enable1  = 1'b1;
        addr1    = cnt;
        rd_issue = 1'b1;
        rd_sel   = 1'b1;
        cnt_nxt  = cnt + 1'b1;
        if (cnt == '1) begin
          state_nxt = D1;
          dcnt_nxt  = '0;
        end
      end
      D1: begin
        dcnt_nxt = dcnt + 2'd1;
        if (dcnt == DRAIN_LAST) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
    if (stop) state_nxt = DONE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_sr <= '0;
      sel_sr <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) addr_sr[i] <= '0;
    end else begin
      vld_sr[0]  <= rd_issue && !start_run && !stop;
      sel_sr[0]  <= rd_sel;
      addr_sr[0] <= rd_sel ? addr1 : addr2;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        vld_sr[i]  <= vld_sr[i-1] && !start_run && !stop;
        sel_sr[i]  <= sel_sr[i-1];
        addr_sr[i] <= addr_sr[i-1];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      error_count <= '0;
      fail_addr   <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      if (start_run) begin
        error_count <= '0;
        fail_addr   <= '0;
      end else if (mismatch) begin
        if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
        if (error_count == 16'd0)    fail_addr   <= cmp_addr;
      end
      done <= (state_nxt == DONE);
      pass <= (state_nxt == DONE) && (error_count == 16'd0) && !mismatch;
    end
  end

endmodule
